// File: rtl/dbus_mem_responder_pkg.sv
// rtl/dbus_mem_responder_pkg.sv - bus types, responder states and the strobe merge helper
package dbus_mem_responder_pkg;

    typedef logic [63:0] u64;
    typedef logic [7:0]  strobe_t;

    typedef enum logic [1:0] {MSIZE1, MSIZE2, MSIZE4, MSIZE8} msize_t;

    typedef struct packed {
        logic    valid;
        u64      addr;
        msize_t  size;
        strobe_t strobe;
        u64      data;
    } dbus_req_t;

    typedef struct packed {
        logic addr_ok;
        logic data_ok;
        u64   data;
    } dbus_resp_t;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} resp_state_t;

    localparam int DEF_DEPTH = 4096;
    localparam int DEF_IDX_W = $clog2(DEF_DEPTH);

    function automatic u64 strobe_merge(input u64 old_word, input u64 wdata, input strobe_t strobe);
        u64 merged;
        merged = old_word;
        for (int b = 0; b < 8; b++) begin
            if (strobe[b]) begin
                merged[b*8 +: 8] = wdata[b*8 +: 8];
            end
        end
        return merged;
    endfunction

endpackage

// File: rtl/dbus_mem_responder_if.sv
// rtl/dbus_mem_responder_if.sv - data bus request/response bundle between core and responder
interface dbus_mem_responder_if;
    import dbus_mem_responder_pkg::*;

    dbus_req_t  dreq;
    dbus_resp_t dresp;

    modport master (output dreq, input dresp);
    modport slave  (input dreq, output dresp);
endinterface

// File: rtl/dbus_mem_responder_lfsr16.sv
// rtl/dbus_mem_responder_lfsr16.sv - 16-bit Fibonacci LFSR (taps 16,14,13,11), free-running
module lfsr16 (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] seed,
    output logic [15:0] out
);

    logic [15:0] lfsr_q;
    logic        feedback;

    assign feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
    assign out      = lfsr_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            lfsr_q <= seed;
        end else begin
            lfsr_q <= {feedback, lfsr_q[15:1]};
        end
    end

endmodule

// File: rtl/dbus_mem_responder.sv
// rtl/dbus_mem_responder.sv - fixed-latency data bus memory responder; DBUS_RESP_STALL_EN adds random wait cycles
module dbus_mem_responder
    import dbus_mem_responder_pkg::*;
#(
    parameter int          DEPTH     = DEF_DEPTH,
    parameter logic [63:0] BASE      = 64'h8000_0000,
    parameter int          LATENCY   = 2,
    parameter int          STALL_MAX = 3
) (
    input  logic                 clk,
    input  logic                 reset,
    dbus_mem_responder_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int CNT_W = $clog2(LATENCY + STALL_MAX + 1);

    resp_state_t      state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    u64               rdata_q;
    u64               mem [DEPTH];

    u64               offset;
    logic             in_range;
    logic             accept;
    logic             is_write;
    logic             want_resp;
    logic             stall_now;
    logic [IDX_W-1:0] idx;

    // A borrow in addr-BASE means the address sits below the window.
    assign offset   = bus.dreq.addr - BASE;
    assign in_range = (bus.dreq.addr >= BASE) && (offset[63:3] < 61'(DEPTH));
    assign idx      = offset[IDX_W+2:3];
    assign accept   = (state_q == IDLE) && bus.dreq.valid;
    assign is_write = |bus.dreq.strobe;

    logic unused_ok;
    assign unused_ok = ^{offset[2:0], bus.dreq.size};

`ifdef DBUS_RESP_STALL_EN
    logic [15:0]      lfsr;
    logic [CNT_W-1:0] stall_q, stall_d;
    logic             unused_lfsr;

    lfsr16 u_lfsr (
        .clk   (clk),
        .reset (reset),
        .seed  (16'hACE1),
        .out   (lfsr)
    );

    assign unused_lfsr = ^lfsr[15:1];
    assign stall_now   = lfsr[0] && (stall_q < CNT_W'(STALL_MAX));

    always_comb begin
        stall_d = stall_q;
        if (want_resp) begin
            stall_d = stall_now ? stall_q + 1'b1 : '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            stall_q <= '0;
        end else begin
            stall_q <= stall_d;
        end
    end
`else
    assign stall_now = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        want_resp = 1'b0;
        bus.dresp = '0;
        unique case (state_q)
            IDLE: begin
                if (bus.dreq.valid) begin
                    cnt_d = CNT_W'(LATENCY - 1);
                    if (cnt_d == '0) begin
                        want_resp = 1'b1;
                    end else begin
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - 1'b1;
                end
                if (cnt_d == '0) begin
                    want_resp = 1'b1;
                end
            end
            RESP: begin
                bus.dresp.addr_ok = 1'b1;
                bus.dresp.data_ok = 1'b1;
                bus.dresp.data    = rdata_q;
                state_d           = IDLE;
            end
            default: state_d = IDLE;
        endcase
        // A stall parks in WAIT with cnt at zero so the check repeats next cycle.
        if (want_resp) begin
            state_d = stall_now ? WAIT : RESP;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdata_q <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            if (accept) begin
                rdata_q <= in_range ? mem[idx] : '0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!reset && accept && in_range && is_write) begin
            mem[idx] <= strobe_merge(mem[idx], bus.dreq.data, bus.dreq.strobe);
        end
    end

endmodule

// File: tb/tb_dbus_mem_responder.sv
// tb/tb_dbus_mem_responder.sv - randomized scoreboard bench for dbus_mem_responder
module tb_dbus_mem_responder;
    import dbus_mem_responder_pkg::*;

    localparam int          DEPTH     = 4096;
    localparam logic [63:0] BASE      = 64'h8000_0000;
    localparam int          LATENCY   = 2;
    localparam int          STALL_MAX = 3;
`ifdef DBUS_RESP_STALL_EN
    localparam int          LAT_MAX   = LATENCY + STALL_MAX;
`else
    localparam int          LAT_MAX   = LATENCY;
`endif

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    dbus_mem_responder_if bus ();

    dbus_mem_responder #(
        .DEPTH     (DEPTH),
        .BASE      (BASE),
        .LATENCY   (LATENCY),
        .STALL_MAX (STALL_MAX)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus.slave)
    );

    typedef struct {
        u64 data;
        int acc;
    } exp_t;

    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    exp_t exp_q[$];
    u64   ref_mem[int];

    always @(posedge clk) cyc <= cyc + 1;

    function automatic u64 merge_ref(input u64 old_word, input u64 wd, input strobe_t s);
        u64 mask;
        mask = 64'h0;
        for (int b = 0; b < 8; b++) begin
            if (s[b]) mask = mask | (64'hFF << (8 * b));
        end
        return (old_word & ~mask) | (wd & mask);
    endfunction

    function automatic bit idx_of(input u64 a, output int idx);
        u64 off;
        idx = 0;
        if (a < BASE) return 1'b0;
        off = a - BASE;
        if ((off / 8) >= 64'(DEPTH)) return 1'b0;
        idx = int'(off / 8);
        return 1'b1;
    endfunction

    // Model update happens at issue time: read returns the pre-write word.
    function automatic u64 model_access(input u64 a, input strobe_t s, input u64 d);
        int idx;
        bit inr;
        u64 pre;
        inr = idx_of(a, idx);
        pre = 64'h0;
        if (inr && ref_mem.exists(idx)) pre = ref_mem[idx];
        if (inr && s != 8'h00) ref_mem[idx] = merge_ref(pre, d, s);
        return pre;
    endfunction

    task automatic issue(input u64 a, input strobe_t s, input u64 d);
        u64 pre;
        bit got;
        pre = model_access(a, s, d);
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = a;
        bus.dreq.size   = MSIZE8;
        bus.dreq.strobe = s;
        bus.dreq.data   = d;
        @(posedge clk);
        #1;
        exp_q.push_back('{data: pre, acc: cyc});
        got = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if (bus.dresp.data_ok) begin
                got = 1'b1;
                break;
            end
        end
        checks++;
        if (!got) begin
            errors++;
            $display("FAIL timeout addr=%h got data_ok=0 want data_ok=1 within 12 cycles", a);
        end
        @(posedge clk);
        #1;
        bus.dreq = '0;
    endtask

    always @(negedge clk) begin
        exp_t e;
        int   lat;
        if (!reset) begin
            checks++;
            if (bus.dresp.addr_ok !== bus.dresp.data_ok) begin
                errors++;
                $display("FAIL addr_ok_pairing got addr_ok=%b want %b", bus.dresp.addr_ok, bus.dresp.data_ok);
            end
            if (bus.dresp.data_ok === 1'b1) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_data_ok got data_ok=1 want no response pending");
                end else begin
                    e   = exp_q.pop_front();
                    lat = cyc - e.acc + 1;
                    if (bus.dresp.data !== e.data) begin
                        errors++;
                        $display("FAIL rdata got %h want %h", bus.dresp.data, e.data);
                    end
                    checks++;
                    if (lat < LATENCY || lat > LAT_MAX) begin
                        errors++;
                        $display("FAIL latency got %0d want %0d..%0d", lat, LATENCY, LAT_MAX);
                    end
                end
            end else begin
                checks++;
                if (bus.dresp !== '0) begin
                    errors++;
                    $display("FAIL idle_outputs got %h want 0", bus.dresp);
                end
            end
        end
    end

    initial begin
        u64      a;
        strobe_t s;
        int      r;

        bus.dreq = '0;
        reset    = 1'b1;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.dresp !== '0) begin
                errors++;
                $display("FAIL reset_outputs got %h want 0", bus.dresp);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (3) @(posedge clk);
        #1;

        for (int w = 0; w < 16; w++) issue(BASE + 64'(w * 8), 8'hFF, {$urandom, $urandom});
        issue(BASE + 64'((DEPTH - 1) * 8), 8'hFF, 64'h0123_4567_89AB_CDEF);

        issue(64'h8000_0010, 8'hFF, 64'h1122_3344_5566_7788);
        issue(64'h8000_0010, 8'h00, 64'h0);

        issue(64'h8000_0028, 8'hFF, 64'h0);
        issue(64'h8000_0028, 8'h0C, 64'hAABB_CCDD_EEFF_0011);
        issue(64'h8000_0028, 8'h00, 64'h0);

        issue(64'h7FFF_FFF8, 8'h00, 64'h0);
        issue(BASE + 64'(DEPTH * 8), 8'hFF, 64'hFFFF_FFFF_FFFF_FFFF);
        issue(BASE + 64'((DEPTH - 1) * 8), 8'h00, 64'h0);
        issue(64'hFFFF_FFFF_FFFF_FFF8, 8'hFF, 64'h55);

        // Reset while the write sits in WAIT: committed data must survive.
        void'(model_access(64'h8000_0020, 8'hFF, 64'hDEAD));
        bus.dreq.valid  = 1'b1;
        bus.dreq.addr   = 64'h8000_0020;
        bus.dreq.size   = MSIZE8;
        bus.dreq.strobe = 8'hFF;
        bus.dreq.data   = 64'hDEAD;
        @(posedge clk);
        #1;
        reset    = 1'b1;
        bus.dreq = '0;
        repeat (3) begin
            @(negedge clk);
            checks++;
            if (bus.dresp.data_ok !== 1'b0) begin
                errors++;
                $display("FAIL reset_abandon got data_ok=%b want 0", bus.dresp.data_ok);
            end
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        issue(64'h8000_0020, 8'h00, 64'h0);

        for (int t = 0; t < 1000; t++) begin
            r = $urandom_range(0, 9);
            if (r < 8)       a = BASE + 64'($urandom_range(0, 15) * 8) + 64'($urandom_range(0, 7));
            else if (r == 8) a = BASE - 64'($urandom_range(1, 4) * 8);
            else             a = BASE + 64'(DEPTH * 8) + 64'($urandom_range(0, 3) * 8);
            s = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'($urandom);
            issue(a, s, {$urandom, $urandom});
            repeat ($urandom_range(0, 2)) begin
                @(posedge clk);
                #1;
            end
        end

        repeat (8) @(posedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL pending_responses got %0d want 0", exp_q.size());
        end
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog got no completion want finish before time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
